// File: rtl/button_debouncer.sv
// Per-button synchronizer, debounce FSM and auto-repeat timer.
// Outputs are a registered debounced level plus single-cycle press, release
// and repeat strobes. No combinational path exists from btn_in to any output.
module button_debouncer #(
    parameter int unsigned CLK_FREQ_MHZ    = 100,
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_US     = 20000,
    parameter int unsigned REPEAT_DELAY_US = 500000,
    parameter int unsigned REPEAT_RATE_US  = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int unsigned DEB_CYC  = DEBOUNCE_US * CLK_FREQ_MHZ;
    localparam int unsigned RDLY_CYC = REPEAT_DELAY_US * CLK_FREQ_MHZ;
    localparam int unsigned RPT_CYC  = REPEAT_RATE_US * CLK_FREQ_MHZ;
    localparam int unsigned RPT_MAX  = (RDLY_CYC > RPT_CYC) ? RDLY_CYC : RPT_CYC;
    localparam int unsigned CNT_W    = ($clog2(DEB_CYC + 1) > 0) ? $clog2(DEB_CYC + 1) : 1;
    localparam int unsigned RPT_W    = ($clog2(RPT_MAX + 1) > 0) ? $clog2(RPT_MAX + 1) : 1;
    localparam bit          REPEAT_EN = (REPEAT_DELAY_US != 0);

    // Terminal counts: a count of N cycles ends when the counter holds N-1.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [RPT_W-1:0] RDLY_LAST = RPT_W'(RDLY_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(RPT_CYC - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } state_e;

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] repeat_q, repeat_d;
    // Set while waiting for the first repeat (long delay), cleared afterwards.
    logic [NUM_BTN-1:0] first_q, first_d;

    state_e           state_q [NUM_BTN];
    state_e           state_d [NUM_BTN];
    logic [CNT_W-1:0] cnt_q   [NUM_BTN];
    logic [CNT_W-1:0] cnt_d   [NUM_BTN];
    logic [RPT_W-1:0] rpt_q   [NUM_BTN];
    logic [RPT_W-1:0] rpt_d   [NUM_BTN];

    // Two-stage synchronizer input chain.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    // Debounce FSM and repeat timer next-state, one independent lane per button.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        first_d   = first_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            unique case (state_q[i])
                StReleased: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StPressPend;
                        cnt_d[i]   = '0;
                    end
                end
                StPressPend: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StReleased;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = StPressed;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        rpt_d[i]   = '0;
                        first_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                StPressed: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StReleasePend;
                        cnt_d[i]   = '0;
                    end else if (REPEAT_EN) begin
                        if (rpt_q[i] == (first_q[i] ? RDLY_LAST : RPT_LAST)) begin
                            repeat_d[i] = 1'b1;
                            rpt_d[i]    = '0;
                            first_d[i]  = 1'b0;
                        end else begin
                            rpt_d[i] = rpt_q[i] + RPT_W'(1);
                        end
                    end
                end
                StReleasePend: begin
                    // Repeat timer stays frozen here; it resumes on a bounce back.
                    if (sync2_q[i]) begin
                        state_d[i] = StPressed;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = StReleased;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = StReleased;
                end
            endcase
        end
    end

    // State registers; reset abandons any pending event without a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            first_q   <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= StReleased;
                cnt_q[i]   <= '0;
                rpt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            first_q   <= first_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with 1 MHz clock, 4-cycle debounce,
// 10-cycle first repeat delay and 3-cycle repeat interval.
module tb_button_debouncer;

    localparam int NB        = 5;
    localparam int EvPress   = 0;
    localparam int EvRelease = 1;
    localparam int EvRepeat  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    typedef struct {
        int            at;
        int            kind;
        logic [NB-1:0] mask;
    } ev_t;

    ev_t           sb[$];
    int            ecount    = 0;
    int            checks    = 0;
    int            errors    = 0;
    logic [NB-1:0] exp_level = '0;

    button_debouncer #(
        .CLK_FREQ_MHZ   (1),
        .NUM_BTN        (NB),
        .DEBOUNCE_US    (4),
        .REPEAT_DELAY_US(10),
        .REPEAT_RATE_US (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Insert an expected event keeping the queue ordered by edge number.
    function automatic void push_ev(input int at, input int kind, input logic [NB-1:0] mask);
        ev_t e;
        int  i;
        e.at   = at;
        e.kind = kind;
        e.mask = mask;
        i      = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endfunction

    // Advance n edges; after each, pop events due now and compare every output.
    task automatic run_cycles(input int n, input string tag);
        logic [NB-1:0] ep, er, et;
        ev_t           e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            ecount++;
            #1;
            ep = '0;
            er = '0;
            et = '0;
            while (sb.size() > 0 && sb[0].at <= ecount) begin
                e = sb.pop_front();
                if (e.at < ecount) begin
                    errors++;
                    $display("FAIL %s late_event: edge=%0d event_at=%0d kind=%0d", tag, ecount,
                             e.at, e.kind);
                end else begin
                    case (e.kind)
                        EvPress: begin
                            ep        = ep | e.mask;
                            exp_level = exp_level | e.mask;
                        end
                        EvRelease: begin
                            er        = er | e.mask;
                            exp_level = exp_level & ~e.mask;
                        end
                        default: et = et | e.mask;
                    endcase
                end
            end
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== {exp_level, ep, er, et}) begin
                errors++;
                $display("FAIL %s edge=%0d level=%b/%b press=%b/%b release=%b/%b repeat=%b/%b",
                         tag, ecount, btn_level, exp_level, btn_press, ep, btn_release, er,
                         btn_repeat, et);
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        btn_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 0",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        run_cycles(2, "reset_held");
        rst_n = 1'b1;
        run_cycles(4, "reset_idle");
    endtask

    task automatic test_clean_press();
        int e;
        e         = ecount + 1;
        btn_in[0] = 1'b1;
        push_ev(e + 6, EvPress, 5'b00001);
        run_cycles(9, "clean_press");
    endtask

    // Entered with button 0 held and pressed; first dip captured three edges after press.
    task automatic test_release_bounce();
        int f0;
        f0        = ecount + 1;
        btn_in[0] = 1'b0;
        push_ev(f0 + 3 + 6, EvRelease, 5'b00001);
        run_cycles(2, "release_dip");
        btn_in[0] = 1'b1;
        run_cycles(1, "release_bounce");
        btn_in[0] = 1'b0;
        run_cycles(25, "release_final");
    endtask

    task automatic test_press_glitch();
        btn_in[0] = 1'b1;
        run_cycles(3, "glitch_high");
        btn_in[0] = 1'b0;
        run_cycles(12, "glitch_low");
    endtask

    task automatic test_auto_repeat();
        int e;
        e         = ecount + 1;
        btn_in[2] = 1'b1;
        push_ev(e + 6, EvPress, 5'b00100);
        // Strobes while the FSM still samples the held level (last at e+31).
        for (int k = 16; k <= 31; k += 3) push_ev(e + k, EvRepeat, 5'b00100);
        push_ev(e + 30 + 6, EvRelease, 5'b00100);
        run_cycles(30, "repeat_hold");
        btn_in[2] = 1'b0;
        run_cycles(15, "repeat_release");
    endtask

    task automatic test_simultaneous();
        int e;
        e      = ecount + 1;
        btn_in = 5'b01001;
        push_ev(e + 6, EvPress, 5'b01001);
        push_ev(e + 9 + 6, EvRelease, 5'b01001);
        run_cycles(9, "simul_hold");
        btn_in = '0;
        run_cycles(12, "simul_release");
    endtask

    task automatic test_reset_mid_debounce();
        int e4;
        int r;
        e4        = ecount + 1;
        btn_in[4] = 1'b1;
        push_ev(e4 + 6, EvPress, 5'b10000);
        run_cycles(9, "rst_pre_hold");
        btn_in[1] = 1'b1;
        run_cycles(5, "rst_pending");
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b, want 0",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        exp_level = '0;
        run_cycles(2, "rst_held");
        rst_n = 1'b1;
        r     = ecount + 1;
        push_ev(r + 6, EvPress, 5'b10010);
        run_cycles(9, "rst_fresh_press");
        btn_in = '0;
        push_ev(r + 9 + 6, EvRelease, 5'b10010);
        run_cycles(12, "rst_release");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_press_glitch();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_debounce();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
